wt_snoop_inv_ctrl: RTL and testbench
====================================

# wt_snoop_inv_ctrl

Snoop-to-invalidate controller for the write-through cache subsystem when the AXI/ACE memory port is used. It sits between the ACE snoop channels and the cache invalidation ports. It accepts one snoop address (AC) at a time and, for invalidating snoop types, drives line-aligned invalidations into the I$ and D$ in parallel. When both caches have acknowledged, it returns a snoop response (CR). No data channel (CD) is used: both L1s are write-through and never hold dirty data.

## Interface
- PLEN, 56, physical address width (riscv::PLEN)
- ICacheLineBytes, 16, I$ line size in bytes, power of two
- DCacheLineBytes, 16, D$ line size in bytes, power of two
- clk_i  in  1  clock; all logic is rising-edge
- rst_ni  in  1  asynchronous active-low reset
- ac_valid_i  in  1  snoop address valid
- ac_ready_o  out  1  snoop address accepted
- ac_addr_i  in  PLEN  snoop physical address
- ac_snoop_i  in  4  ACE snoop type
- cr_valid_o  out  1  snoop response valid
- cr_ready_i  in  1  snoop response accepted
- cr_resp_o  out  5  response: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
- icache_inv_req_o  out  1  I$ invalidate request
- icache_inv_addr_o  out  PLEN  I$ line address
- icache_inv_ack_i  in  1  I$ invalidate done
- dcache_inv_req_o  out  1  D$ invalidate request
- dcache_inv_addr_o  out  PLEN  D$ line address
- dcache_inv_ack_i  in  1  D$ invalidate done
- snoop_cnt_o  out  32  number of completed snoops, wraps
- busy_o  out  1  high in any state other than IDLE

## Operation
FSM states: IDLE, INV, RESP.

**IDLE**
- ac_ready_o = 1. All other handshake outputs are 0.
- On ac_valid_i & ac_ready_o, register addr and snoop.
- Invalidating types are 4'b0111 ReadUnique, 4'b1001 CleanInvalid and 4'b1101 MakeInvalid.
  - Invalidating type: go to INV.
  - Any other type: go to RESP.

**INV**
- Both inv_req outputs are driven high from the state's first cycle.
- icache_inv_addr_o = addr with the low log2(ICacheLineBytes) bits zeroed. dcache_inv_addr_o is formed the same way with DCacheLineBytes.
- Each request is held high, with a stable address, until its ack is sampled high while the request is high. It drops in the following cycle.
- A per-cache done flag records the ack.
- The two acks may arrive in the same cycle or in either order, any number of cycles apart.
- An ack arriving while the request is low is ignored.
- When both done flags are set (the last ack is sampled): go to RESP. Clear the flags.

**RESP**
- cr_valid_o = 1, held until cr_ready_i.
- cr_resp_o:
  - 5'b00000 after an invalidation.
  - 5'b01000 (IsShared) for non-invalidating snoops.
  - DataTransfer, PassDirty and Error are always 0.
- On cr_valid_o & cr_ready_i: snoop_cnt_o increments by 1 (modulo 2^32), then go to IDLE.

Only one snoop is outstanding at a time. AC is back-pressured (ac_ready_o = 0) in INV and RESP.

Reset may be asserted at any time, including mid-INV or mid-RESP.
- All state is cleared immediately and the in-flight snoop is dropped.
- No response is issued for the dropped snoop.

## Timing
- Reset values: ac_ready_o = 1, busy_o = 0. cr_valid_o, cr_resp_o, both inv_req_o, both inv_addr_o and snoop_cnt_o are all 0.
- All outputs are registered, except ac_ready_o and busy_o, which decode the state register.
- Invalidating snoop accepted at cycle 0:
  - inv_reqs are high in cycle 1.
  - If both acks arrive in cycle 1, cr_valid_o is high in cycle 2.
  - If cr_ready_i is also high in cycle 2, ac_ready_o is high in cycle 3.
- Non-invalidating snoop accepted at cycle 0: cr_valid_o is high in cycle 1.
- Minimum spacing between accepted snoops:
  - 3 cycles for invalidating snoops.
  - 2 cycles for non-invalidating snoops.
- cr_resp_o is stable while cr_valid_o is high and cr_ready_i is low.

## Test plan
- **Reset:** rst_ni low for 3 cycles -> ac_ready_o = 1; cr_valid_o, both inv_req_o, busy_o all 0; snoop_cnt_o = 0.
- **MakeInvalid, same-cycle acks:** snoop 4'b1101, addr 0x80001234, acks tied high.
  - Cycle 1: both inv_req = 1, both inv_addr = 0x80001230.
  - Cycle 2: cr_valid_o = 1, cr_resp_o = 0.
  - After handshake: snoop_cnt_o = 1.
- **Staggered acks:** ReadUnique; D$ ack after 2 cycles, I$ ack after 5 cycles.
  - dcache_inv_req_o drops after its ack; icache_inv_req_o stays high.
  - cr_valid_o rises exactly 1 cycle after the I$ ack.
  - Stray acks while requests are low have no effect.
- **ReadShared (4'b0001):** no inv_req asserted; cr_valid_o high in cycle 1 with cr_resp_o = 5'b01000.
- **Response back-pressure:** cr_ready_i low for 4 cycles -> cr_valid_o and cr_resp_o held stable, ac_ready_o = 0, a new ac_valid_i is not accepted.
- **Reset mid-INV, then counter wrap:**
  - Assert rst_ni low during INV -> next cycle all outputs are at reset values; the following snoop completes normally.
  - With snoop_cnt_o forced to 0xFFFFFFFF, one completion -> snoop_cnt_o = 0.

Source files
------------

// File: rtl/wt_snoop_inv_ctrl.sv
// Snoop-to-invalidate controller: turns ACE invalidating snoops into parallel
// I$/D$ line invalidations and answers every snoop on CR without data.
module wt_snoop_inv_ctrl #(
    parameter int unsigned PLEN            = 56,
    parameter int unsigned ICacheLineBytes = 16,
    parameter int unsigned DCacheLineBytes = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ac_valid_i,
    output logic            ac_ready_o,
    input  logic [PLEN-1:0] ac_addr_i,
    input  logic [3:0]      ac_snoop_i,
    output logic            cr_valid_o,
    input  logic            cr_ready_i,
    output logic [4:0]      cr_resp_o,
    output logic            icache_inv_req_o,
    output logic [PLEN-1:0] icache_inv_addr_o,
    input  logic            icache_inv_ack_i,
    output logic            dcache_inv_req_o,
    output logic [PLEN-1:0] dcache_inv_addr_o,
    input  logic            dcache_inv_ack_i,
    output logic [31:0]     snoop_cnt_o,
    output logic            busy_o
);

    localparam int unsigned IOFF = $clog2(ICacheLineBytes);
    localparam int unsigned DOFF = $clog2(DCacheLineBytes);
    localparam logic [PLEN-1:0] IMASK = {PLEN{1'b1}} << IOFF;
    localparam logic [PLEN-1:0] DMASK = {PLEN{1'b1}} << DOFF;
    localparam logic [4:0] RESP_IS_SHARED = 5'b01000;

    typedef enum logic [1:0] {IDLE, INV, RESP} state_t;

    state_t          state_q, state_d;
    logic            ireq_q, ireq_d, dreq_q, dreq_d;
    logic            idone_q, idone_d, ddone_q, ddone_d;
    logic [PLEN-1:0] iaddr_q, iaddr_d, daddr_q, daddr_d;
    logic            cr_valid_q, cr_valid_d;
    logic [4:0]      cr_resp_q, cr_resp_d;
    logic [31:0]     snoop_cnt_q, snoop_cnt_d;
    logic            is_inv, iack_hit, dack_hit;

    assign is_inv   = (ac_snoop_i == 4'b0111) || (ac_snoop_i == 4'b1001) ||
                      (ac_snoop_i == 4'b1101);
    // An ack only counts while its own request is being presented.
    assign iack_hit = ireq_q & icache_inv_ack_i;
    assign dack_hit = dreq_q & dcache_inv_ack_i;

    always_comb begin
        state_d     = state_q;
        ireq_d      = ireq_q;
        dreq_d      = dreq_q;
        idone_d     = idone_q;
        ddone_d     = ddone_q;
        iaddr_d     = iaddr_q;
        daddr_d     = daddr_q;
        cr_valid_d  = cr_valid_q;
        cr_resp_d   = cr_resp_q;
        snoop_cnt_d = snoop_cnt_q;
        case (state_q)
            IDLE: begin
                if (ac_valid_i) begin
                    iaddr_d = ac_addr_i & IMASK;
                    daddr_d = ac_addr_i & DMASK;
                    if (is_inv) begin
                        state_d = INV;
                        ireq_d  = 1'b1;
                        dreq_d  = 1'b1;
                    end else begin
                        state_d    = RESP;
                        cr_valid_d = 1'b1;
                        cr_resp_d  = RESP_IS_SHARED;
                    end
                end
            end
            INV: begin
                if (iack_hit) begin
                    ireq_d  = 1'b0;
                    idone_d = 1'b1;
                end
                if (dack_hit) begin
                    dreq_d  = 1'b0;
                    ddone_d = 1'b1;
                end
                if ((idone_q || iack_hit) && (ddone_q || dack_hit)) begin
                    state_d    = RESP;
                    idone_d    = 1'b0;
                    ddone_d    = 1'b0;
                    cr_valid_d = 1'b1;
                    cr_resp_d  = 5'b00000;
                end
            end
            RESP: begin
                if (cr_ready_i) begin
                    state_d     = IDLE;
                    cr_valid_d  = 1'b0;
                    cr_resp_d   = 5'b00000;
                    snoop_cnt_d = snoop_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ireq_q      <= 1'b0;
            dreq_q      <= 1'b0;
            idone_q     <= 1'b0;
            ddone_q     <= 1'b0;
            iaddr_q     <= '0;
            daddr_q     <= '0;
            cr_valid_q  <= 1'b0;
            cr_resp_q   <= '0;
            snoop_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ireq_q      <= ireq_d;
            dreq_q      <= dreq_d;
            idone_q     <= idone_d;
            ddone_q     <= ddone_d;
            iaddr_q     <= iaddr_d;
            daddr_q     <= daddr_d;
            cr_valid_q  <= cr_valid_d;
            cr_resp_q   <= cr_resp_d;
            snoop_cnt_q <= snoop_cnt_d;
        end
    end

    assign ac_ready_o        = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign icache_inv_req_o  = ireq_q;
    assign dcache_inv_req_o  = dreq_q;
    assign icache_inv_addr_o = iaddr_q;
    assign dcache_inv_addr_o = daddr_q;
    assign cr_valid_o        = cr_valid_q;
    assign cr_resp_o         = cr_resp_q;
    assign snoop_cnt_o       = snoop_cnt_q;

endmodule

// File: tb/tb_wt_snoop_inv_ctrl.sv
// Directed, table-driven bench for wt_snoop_inv_ctrl with hand-written
// sequences for reset during an invalidation and snoop counter wrap.
module tb_wt_snoop_inv_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ac_valid_i, ac_ready_o;
    logic [55:0] ac_addr_i;
    logic [3:0]  ac_snoop_i;
    logic        cr_valid_o, cr_ready_i;
    logic [4:0]  cr_resp_o;
    logic        icache_inv_req_o, icache_inv_ack_i;
    logic [55:0] icache_inv_addr_o;
    logic        dcache_inv_req_o, dcache_inv_ack_i;
    logic [55:0] dcache_inv_addr_o;
    logic [31:0] snoop_cnt_o;
    logic        busy_o;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [31:0] expCnt;

    typedef struct {
        logic [3:0]  snoop;
        logic [55:0] addr;
        int          iDly;
        int          dDly;
        int          crDly;
        bit          expInv;
        logic [4:0]  expResp;
        logic [55:0] expLine;
    } vec_t;

    vec_t vecs[8];

    always #5 clk_i = ~clk_i;

    wt_snoop_inv_ctrl #(.PLEN(56), .ICacheLineBytes(16), .DCacheLineBytes(16)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .ac_valid_i        (ac_valid_i),
        .ac_ready_o        (ac_ready_o),
        .ac_addr_i         (ac_addr_i),
        .ac_snoop_i        (ac_snoop_i),
        .cr_valid_o        (cr_valid_o),
        .cr_ready_i        (cr_ready_i),
        .cr_resp_o         (cr_resp_o),
        .icache_inv_req_o  (icache_inv_req_o),
        .icache_inv_addr_o (icache_inv_addr_o),
        .icache_inv_ack_i  (icache_inv_ack_i),
        .dcache_inv_req_o  (dcache_inv_req_o),
        .dcache_inv_addr_o (dcache_inv_addr_o),
        .dcache_inv_ack_i  (dcache_inv_ack_i),
        .snoop_cnt_o       (snoop_cnt_o),
        .busy_o            (busy_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " ac_ready"}, 64'(ac_ready_o), 64'd1);
        checkOutput({tag, " busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, " cr_valid"}, 64'(cr_valid_o), 64'd0);
        checkOutput({tag, " cr_resp"}, 64'(cr_resp_o), 64'd0);
        checkOutput({tag, " ireq"}, 64'(icache_inv_req_o), 64'd0);
        checkOutput({tag, " dreq"}, 64'(dcache_inv_req_o), 64'd0);
        checkOutput({tag, " iaddr"}, 64'(icache_inv_addr_o), 64'd0);
        checkOutput({tag, " daddr"}, 64'(dcache_inv_addr_o), 64'd0);
        checkOutput({tag, " cnt"}, 64'(snoop_cnt_o), 64'd0);
    endtask

    // One complete snoop; acks are raised during the accept cycle (stray, reqs low)
    // and held high after their nominal cycle so later acks are stray as well.
    task automatic applyStimulus(input vec_t v, input int idx);
        string t;
        int    maxDly;
        logic [4:0] heldResp;
        t = $sformatf("v%0d", idx);
        checkOutput({t, " idle ac_ready"}, 64'(ac_ready_o), 64'd1);
        ac_valid_i = 1'b1;
        ac_addr_i  = v.addr;
        ac_snoop_i = v.snoop;
        icache_inv_ack_i = 1'b1;
        dcache_inv_ack_i = 1'b1;
        @(negedge clk_i);
        ac_valid_i = 1'b0;
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        if (v.expInv) begin
            maxDly = (v.iDly > v.dDly) ? v.iDly : v.dDly;
            for (int k = 1; k <= maxDly; k++) begin
                checkOutput($sformatf("%s c%0d ireq", t, k), 64'(icache_inv_req_o), 64'(k <= v.iDly));
                checkOutput($sformatf("%s c%0d dreq", t, k), 64'(dcache_inv_req_o), 64'(k <= v.dDly));
                checkOutput($sformatf("%s c%0d cr_valid", t, k), 64'(cr_valid_o), 64'd0);
                checkOutput($sformatf("%s c%0d ac_ready", t, k), 64'(ac_ready_o), 64'd0);
                if (k == 1) begin
                    checkOutput({t, " iaddr"}, 64'(icache_inv_addr_o), 64'(v.expLine));
                    checkOutput({t, " daddr"}, 64'(dcache_inv_addr_o), 64'(v.expLine));
                end
                icache_inv_ack_i = (k >= v.iDly);
                dcache_inv_ack_i = (k >= v.dDly);
                @(negedge clk_i);
            end
            icache_inv_ack_i = 1'b0;
            dcache_inv_ack_i = 1'b0;
        end
        checkOutput({t, " resp cr_valid"}, 64'(cr_valid_o), 64'd1);
        checkOutput({t, " resp cr_resp"}, 64'(cr_resp_o), 64'(v.expResp));
        checkOutput({t, " resp ireq"}, 64'(icache_inv_req_o), 64'd0);
        checkOutput({t, " resp dreq"}, 64'(dcache_inv_req_o), 64'd0);
        checkOutput({t, " resp busy"}, 64'(busy_o), 64'd1);
        heldResp = cr_resp_o;
        for (int j = 0; j < v.crDly; j++) begin
            cr_ready_i = 1'b0;
            ac_valid_i = 1'b1;
            ac_snoop_i = 4'b0000;
            @(negedge clk_i);
            checkOutput($sformatf("%s bp%0d cr_valid", t, j), 64'(cr_valid_o), 64'd1);
            checkOutput($sformatf("%s bp%0d cr_resp", t, j), 64'(cr_resp_o), 64'(heldResp));
            checkOutput($sformatf("%s bp%0d ac_ready", t, j), 64'(ac_ready_o), 64'd0);
        end
        cr_ready_i = 1'b1;
        ac_valid_i = 1'b0;
        @(negedge clk_i);
        cr_ready_i = 1'b0;
        expCnt = expCnt + 32'd1;
        checkOutput({t, " done cr_valid"}, 64'(cr_valid_o), 64'd0);
        checkOutput({t, " done ac_ready"}, 64'(ac_ready_o), 64'd1);
        checkOutput({t, " done busy"}, 64'(busy_o), 64'd0);
        checkOutput({t, " done cnt"}, 64'(snoop_cnt_o), 64'(expCnt));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'b1101, 56'h0000_0080_0012_34, 1, 1, 0, 1'b1, 5'b00000, 56'h0000_0080_0012_30};
        vecs[1] = '{4'b0111, 56'h0000_0000_AB_CDEF, 5, 2, 0, 1'b1, 5'b00000, 56'h0000_0000_AB_CDE0};
        vecs[2] = '{4'b0001, 56'h0000_0000_0012_34, 0, 0, 0, 1'b0, 5'b01000, 56'h0};
        vecs[3] = '{4'b1001, 56'hFF_FFFF_FFFF_FFFF, 3, 3, 1, 1'b1, 5'b00000, 56'hFF_FFFF_FFFF_FFF0};
        vecs[4] = '{4'b1000, 56'h0000_0000_0000_40, 0, 0, 4, 1'b0, 5'b01000, 56'h0};
        vecs[5] = '{4'b1101, 56'h0000_0000_0000_0F, 2, 4, 4, 1'b1, 5'b00000, 56'h0000_0000_0000_00};
        vecs[6] = '{4'b0000, 56'h0000_0000_0055_55, 0, 0, 0, 1'b0, 5'b01000, 56'h0};
        vecs[7] = '{4'b1100, 56'h0000_0000_0066_66, 0, 0, 2, 1'b0, 5'b01000, 56'h0};

        rst_ni = 1'b0;
        ac_valid_i = 1'b0;
        ac_addr_i = '0;
        ac_snoop_i = '0;
        cr_ready_i = 1'b0;
        icache_inv_ack_i = 1'b0;
        dcache_inv_ack_i = 1'b0;
        expCnt = '0;
        repeat (3) @(negedge clk_i);
        checkResetValues("rst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkResetValues("post_rst");

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Reset dropped in the middle of an invalidation.
        ac_valid_i = 1'b1;
        ac_addr_i  = 56'h1000;
        ac_snoop_i = 4'b1101;
        @(negedge clk_i);
        ac_valid_i = 1'b0;
        checkOutput("midinv ireq", 64'(icache_inv_req_o), 64'd1);
        checkOutput("midinv busy", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        expCnt = '0;
        @(negedge clk_i);
        checkResetValues("midinv_rst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkResetValues("midinv_rel");
        applyStimulus(vecs[0], 10);

        // Counter wrap from all-ones.
        dut.snoop_cnt_q = 32'hFFFF_FFFF;
        expCnt = 32'hFFFF_FFFF;
        @(negedge clk_i);
        checkOutput("wrap preload", 64'(snoop_cnt_o), 64'hFFFF_FFFF);
        applyStimulus(vecs[2], 11);
        checkOutput("wrap zero", 64'(snoop_cnt_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
